// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher: one outstanding imem request at a time, with a small FIFO of
// {pc, instr} pairs feeding IF/ID. Wrong-path fetches are squashed on an EX redirect.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ack,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       deq_ready,
  output logic                       instr_valid,
  output logic [31:0]                pcF,
  output logic [31:0]                instrF,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [AW-1:0]   PTR_ZERO = AW'(0);
  localparam logic [31:0]     NOP      = 32'h0000_0013;
  localparam logic [31:0]     PC_STEP  = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_addr;
  logic          r_req;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_has_room;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_pc_inc;
  logic [CW-1:0] w_count_next;

  assign w_empty     = (r_count == CNT_ZERO);
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
  assign w_pc_inc    = r_fetch_pc + PC_STEP;
  // A redirect squashes both the in-flight ack data and any pop this cycle.
  assign w_push      = (r_state == S_WAIT) && imem_ack && !redirect;
  assign instr_valid = !w_empty && !redirect;
  assign w_pop       = instr_valid && deq_ready;
  assign w_has_room  = (w_count_next < CNT_FULL);

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign count     = r_count;
  assign pcF       = w_empty ? 32'h0000_0000 : r_pc_mem[r_rd_ptr];
  assign instrF    = w_empty ? NOP : r_instr_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (redirect) begin
      w_count_next = CNT_ZERO;
    end else if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - CNT_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // Fetch FSM; imem_req/imem_addr are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
          end else if (w_has_room) begin
            r_state <= S_WAIT;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        S_WAIT: begin
          if (imem_ack && redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
          end else if (imem_ack) begin
            r_fetch_pc <= w_pc_inc;
            if (w_has_room) begin
              r_addr <= w_pc_inc;
            end else begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end else if (redirect) begin
            // Request cannot be withdrawn; keep it up and discard its data.
            r_fetch_pc <= w_redir_pc;
            r_state    <= S_DROP;
          end
        end
        S_DROP: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
          end
          if (imem_ack) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count  <= CNT_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_wr_ptr <= PTR_ZERO;
    end else if (redirect) begin
      r_count  <= CNT_ZERO;
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_next;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
      r_instr_mem[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic checked by a
// queue-based fetch-stream model running on every falling edge.
module tb_fetch_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        deq_ready;
  logic        instr_valid;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic [2:0]  count;

  int tests  = 0;
  int failed = 0;

  int          mem_lat     = 1;
  int          mem_cnt     = 0;
  bit          mem_rand    = 1'b0;
  logic [31:0] poison_addr = 32'hFFFF_FFFF;

  logic [63:0] mq[$];
  logic [31:0] m_next_pc;
  bit          m_stale;
  bit          m_pred_valid;
  bit          m_pred_req;
  bit          m_prev_req;
  bit          m_prev_ack;
  logic [31:0] m_prev_addr;
  int          m_pops = 0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .deq_ready(deq_ready), .instr_valid(instr_valid),
    .pcF(pcF), .instrF(instrF), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Instruction memory: acks after mem_lat cycles of a held request; data = 0xA0 + addr.
  task automatic mem_driver();
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end else if (imem_req) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = (imem_addr == poison_addr) ? 32'h0000_DEAD : (32'h0000_00A0 + imem_addr);
          mem_cnt    = 0;
          if (mem_rand) mem_lat = $urandom_range(1, 3);
        end else begin
          imem_ack = 1'b0;
        end
      end else begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end
    end
  endtask

  // Reference model: the queue holds the architectural stream of fetched {pc, instr}.
  task automatic monitor();
    logic [63:0] head;
    bit          pushing;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mq.delete();
        m_next_pc    = RESET_PC;
        m_stale      = 1'b0;
        m_pred_valid = 1'b0;
        m_prev_req   = 1'b0;
        m_prev_ack   = 1'b0;
      end else begin
        tests++;
        if (count !== 3'(mq.size())) begin
          failed++;
          $display("FAIL mon_count t=%0t got %0d exp %0d", $time, count, mq.size());
        end
        tests++;
        if (instr_valid !== ((mq.size() != 0) && !redirect)) begin
          failed++;
          $display("FAIL mon_valid t=%0t got %b exp %b", $time, instr_valid, (mq.size() != 0) && !redirect);
        end
        if (mq.size() != 0) begin
          head = mq[0];
          tests++;
          if (pcF !== head[63:32] || instrF !== head[31:0]) begin
            failed++;
            $display("FAIL mon_head t=%0t got %h/%h exp %h/%h", $time, pcF, instrF, head[63:32], head[31:0]);
          end
        end else begin
          tests++;
          if (pcF !== 32'h0 || instrF !== NOP) begin
            failed++;
            $display("FAIL mon_empty_head t=%0t got %h/%h exp 0/%h", $time, pcF, instrF, NOP);
          end
        end
        if (m_pred_valid) begin
          tests++;
          if (imem_req !== m_pred_req) begin
            failed++;
            $display("FAIL mon_req t=%0t got %b exp %b", $time, imem_req, m_pred_req);
          end
        end
        if (m_prev_req && !m_prev_ack && imem_req) begin
          tests++;
          if (imem_addr !== m_prev_addr) begin
            failed++;
            $display("FAIL mon_addr_stable t=%0t got %h exp %h", $time, imem_addr, m_prev_addr);
          end
        end
        m_prev_req  = imem_req;
        m_prev_ack  = imem_ack;
        m_prev_addr = imem_addr;

        if (redirect) begin
          mq.delete();
          m_next_pc  = redirect_pc & 32'hFFFF_FFFC;
          m_pred_req = imem_req && !imem_ack;
          m_stale    = m_pred_req;
        end else begin
          if (mq.size() != 0 && deq_ready) begin
            void'(mq.pop_front());
            m_pops++;
          end
          pushing = imem_req && imem_ack && !m_stale;
          if (pushing) begin
            tests++;
            if (imem_addr !== m_next_pc || mq.size() >= DEPTH) begin
              failed++;
              $display("FAIL mon_push t=%0t addr %h exp %h size %0d", $time, imem_addr, m_next_pc, mq.size());
            end
            mq.push_back({imem_addr, imem_rdata});
            m_next_pc = m_next_pc + 32'h4;
          end
          if (imem_req && !imem_ack) begin
            m_pred_req = 1'b1;
          end else if (imem_req && imem_ack && m_stale) begin
            m_pred_req = 1'b0;
            m_stale    = 1'b0;
          end else begin
            m_pred_req = (mq.size() < DEPTH);
          end
        end
        m_pred_valid = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    cyc();
    rst       = 1'b0;
    imem_ack  = 1'b0;
    mem_cnt   = 0;
    redirect  = 1'b0;
    deq_ready = 1'b0;
    mem_rand  = 1'b0;
    mem_lat   = 1;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rst_req got %b exp 0", imem_req); end
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL rst_count got %0d exp 0", count); end
    tests++; if (pcF !== 32'h0) begin failed++; $display("FAIL rst_pcF got %h exp 0", pcF); end
    tests++; if (instrF !== NOP) begin failed++; $display("FAIL rst_instrF got %h exp %h", instrF, NOP); end
  endtask

  task automatic test_sequential();
    int n = 0;
    logic [31:0] a0, a1, a2;
    do_reset();
    deq_ready = 1'b1;
    while (!(imem_req && imem_ack) && n < 20) begin cyc(); n++; end
    tests++; if (!(imem_req && imem_ack)) begin failed++; $display("FAIL seq_first_ack got none exp ack"); end
    a0 = imem_addr;
    cyc();
    tests++; if (instr_valid !== 1'b1) begin failed++; $display("FAIL seq_valid got %b exp 1", instr_valid); end
    tests++; if (pcF !== 32'h0) begin failed++; $display("FAIL seq_pcF0 got %h exp 0", pcF); end
    tests++; if (instrF !== 32'hA0) begin failed++; $display("FAIL seq_instrF0 got %h exp a0", instrF); end
    a1 = imem_addr;
    cyc();
    tests++; if (pcF !== 32'h4) begin failed++; $display("FAIL seq_pcF1 got %h exp 4", pcF); end
    a2 = imem_addr;
    tests++;
    if (a0 !== 32'h0 || a1 !== 32'h4 || a2 !== 32'h8) begin
      failed++; $display("FAIL seq_addrs got %h %h %h exp 0 4 8", a0, a1, a2);
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_full();
    int n = 0;
    int acks = 0;
    do_reset();
    while (acks < 4 && n < 30) begin
      cyc(); n++;
      if (imem_req && imem_ack) acks++;
    end
    tests++; if (acks != 4) begin failed++; $display("FAIL full_acks got %0d exp 4", acks); end
    cyc();
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL full_req_low got %b exp 0", imem_req); end
    tests++; if (count !== 3'd4) begin failed++; $display("FAIL full_count got %0d exp 4", count); end
    cyc();
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL full_req_hold got %b exp 0", imem_req); end
    deq_ready = 1'b1;
    cyc();
    deq_ready = 1'b0;
    tests++; if (count !== 3'd3) begin failed++; $display("FAIL full_pop_count got %0d exp 3", count); end
    tests++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      failed++; $display("FAIL full_rereq got req=%b addr=%h exp req=1 addr=10", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_drop();
    int n = 0;
    do_reset();
    mem_lat     = 3;
    poison_addr = 32'h8;
    while (!(imem_req && imem_addr == 32'h8) && n < 40) begin cyc(); n++; end
    tests++; if (!(imem_req && imem_addr == 32'h8)) begin failed++; $display("FAIL drop_reach8 got addr %h exp 8", imem_addr); end
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL drop_valid_redir got %b exp 0", instr_valid); end
    cyc();
    redirect = 1'b0;
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failed++; $display("FAIL drop_hold got req=%b addr=%h exp 1/8", imem_req, imem_addr); end
    tests++; if (imem_ack !== 1'b1) begin failed++; $display("FAIL drop_ack got %b exp 1", imem_ack); end
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL drop_count got %0d exp 0", count); end
    cyc();
    tests++; if (imem_req !== 1'b0 || count !== 3'd0) begin failed++; $display("FAIL drop_idle got req=%b cnt=%0d exp 0/0", imem_req, count); end
    cyc();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failed++; $display("FAIL drop_newreq got req=%b addr=%h exp 1/100", imem_req, imem_addr); end
    n = 0;
    while (!instr_valid && n < 20) begin cyc(); n++; end
    tests++;
    if (instr_valid !== 1'b1 || pcF !== 32'h100 || instrF !== 32'h1A0) begin
      failed++; $display("FAIL drop_head got v=%b %h/%h exp 1 100/1a0", instr_valid, pcF, instrF);
    end
    poison_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_redirect_ack();
    int n = 0;
    do_reset();
    while (!(count == 3'd2 && imem_ack) && n < 20) begin cyc(); n++; end
    tests++; if (!(count == 3'd2 && imem_ack)) begin failed++; $display("FAIL rack_setup got cnt=%0d ack=%b exp 2/1", count, imem_ack); end
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    cyc();
    redirect = 1'b0;
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL rack_count got %0d exp 0", count); end
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL rack_idle got %b exp 0", imem_req); end
    cyc();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failed++; $display("FAIL rack_addr got req=%b addr=%h exp 1/200", imem_req, imem_addr); end
  endtask

  task automatic test_push_pop();
    int n = 0;
    do_reset();
    while (count != 3'd2 && n < 20) begin cyc(); n++; end
    deq_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tests++; if (count !== 3'd2) begin failed++; $display("FAIL pp_count[%0d] got %0d exp 2", i, count); end
      tests++; if (pcF !== 32'(4 * i)) begin failed++; $display("FAIL pp_pcF[%0d] got %h exp %h", i, pcF, 32'(4 * i)); end
      tests++; if (imem_ack !== 1'b1) begin failed++; $display("FAIL pp_ack[%0d] got %b exp 1", i, imem_ack); end
      cyc();
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    mem_lat = 3;
    while (!(count >= 3'd1 && imem_req) && n < 30) begin cyc(); n++; end
    #2;
    rst      = 1'b0;
    imem_ack = 1'b0;
    mem_cnt  = 0;
    #1;
    tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL arst_req got %b exp 0", imem_req); end
    tests++; if (instr_valid !== 1'b0) begin failed++; $display("FAIL arst_valid got %b exp 0", instr_valid); end
    tests++; if (count !== 3'd0) begin failed++; $display("FAIL arst_count got %0d exp 0", count); end
    tests++; if (pcF !== 32'h0 || instrF !== NOP) begin failed++; $display("FAIL arst_head got %h/%h exp 0/%h", pcF, instrF, NOP); end
    cyc();
    cyc();
    rst = 1'b1;
    n   = 0;
    while (!imem_req && n < 10) begin cyc(); n++; end
    tests++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin failed++; $display("FAIL arst_first got req=%b addr=%h exp 1/%h", imem_req, imem_addr, RESET_PC); end
  endtask

  task automatic test_random();
    int pops0;
    do_reset();
    mem_rand = 1'b1;
    pops0    = m_pops;
    for (int i = 0; i < 3000; i++) begin
      deq_ready   = ($urandom_range(0, 1) == 1);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom & 32'h0000_0FFF;
      cyc();
    end
    redirect  = 1'b0;
    deq_ready = 1'b0;
    mem_rand  = 1'b0;
    mem_lat   = 1;
    tests++; if (m_pops - pops0 < 100) begin failed++; $display("FAIL rand_activity got %0d pops exp >=100", m_pops - pops0); end
  endtask

  initial begin
    rst         = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    deq_ready   = 1'b0;
    fork
      mem_driver();
      monitor();
    join_none
    test_reset();
    test_sequential();
    test_full();
    test_redirect_drop();
    test_redirect_ack();
    test_push_pop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
